// File: rtl/param_commit_sequencer.sv
// Host parameter write queue with an atomic shadow-to-bank commit at each sim-step tick.
// Writes are staged into a shadow bank, then copied to params_out_o in a single cycle.
module param_commit_sequencer #(
   parameter int unsigned          NPARAM       = 8,
   parameter int unsigned          AW           = 3,
   parameter int unsigned          DEPTH        = 8,
   parameter logic [NPARAM*32-1:0] RESET_VALUES = '0
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     wr_valid_i,
   input  logic [AW-1:0]            wr_addr_i,
   input  logic [31:0]              wr_data_i,
   output logic                     wr_ready_o,
   input  logic                     sim_tick_i,
   output logic [NPARAM*32-1:0]     params_out_o,
   output logic                     commit_done_o,
   output logic [$clog2(DEPTH):0]   pending_o,
   output logic                     busy_o,
   output logic [2:0]               err_flags_o,
   input  logic                     err_clear_i
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic [CntW-1:0]        count_q, count_d;
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [2:0]             err_q, err_d;
   logic                   commit_done_q;
   logic [NPARAM*32-1:0]   params_q;
   logic [31:0]            shadow_q [NPARAM];
   logic [NPARAM*32-1:0]   shadow_flat;
   logic [AW+31:0]         fifo_mem [DEPTH];
   logic [AW+31:0]         pop_entry;
   logic [AW-1:0]          pop_addr;
   logic [31:0]            pop_data;
   logic                   push, pop, pop_bad;

   assign wr_ready_o = (count_q < CntW'(DEPTH));
   assign push       = wr_valid_i & wr_ready_o;
   assign pop        = (state_q == StDrain);
   assign pop_entry  = fifo_mem[rd_ptr_q];
   assign pop_addr   = pop_entry[AW+31:32];
   assign pop_data   = pop_entry[31:0];
   assign pop_bad    = pop & (32'(pop_addr) >= NPARAM);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
   end

   // A sticky set in the same cycle as err_clear_i wins.
   always_comb begin
      err_d    = err_q & ~{3{err_clear_i}};
      err_d[0] = err_d[0] | (wr_valid_i & ~wr_ready_o);
      err_d[1] = err_d[1] | pop_bad;
      err_d[2] = err_d[2] | (sim_tick_i & (state_q != StIdle));
   end

   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < NPARAM; i++) begin
         shadow_flat[32*i +: 32] = shadow_q[i];
      end
   end

   // Storage needs no reset: pointers and occupancy define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {wr_addr_i, wr_data_i};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         err_q         <= '0;
         commit_done_q <= 1'b0;
         params_q      <= RESET_VALUES;
         for (int i = 0; i < NPARAM; i++) begin
            shadow_q[i] <= RESET_VALUES[32*i +: 32];
         end
      end else begin
         commit_done_q <= 1'b0;
         count_q       <= count_d;
         err_q         <= err_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            for (int i = 0; i < NPARAM; i++) begin
               if (pop_addr == AW'(i)) begin
                  shadow_q[i] <= pop_data;
               end
            end
         end
         case (state_q)
            StIdle: begin
               if (sim_tick_i) begin
                  cnt_q   <= count_q;
                  state_q <= (count_q != '0) ? StDrain : StCommit;
               end
            end
            StDrain: begin
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StCommit;
               end
            end
            StCommit: begin
               params_q      <= shadow_flat;
               commit_done_q <= 1'b1;
               state_q       <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign params_out_o  = params_q;
   assign commit_done_o = commit_done_q;
   assign pending_o     = count_q;
   assign busy_o        = (state_q != StIdle);
   assign err_flags_o   = err_q;

endmodule

// File: tb/tb_param_commit_sequencer.sv
// Directed bench for param_commit_sequencer with hand-computed expected bank contents.
module tb_param_commit_sequencer;

   localparam int unsigned NP = 8;
   localparam logic [NP*32-1:0] RV = {32'hc0000000, 32'h40490fdb, 32'h3dcccccd, 32'h41200000,
                                      32'h3f000000, 32'h40000000, 32'h42a00000, 32'h3f800000};

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wr_valid = 1'b0;
   logic [3:0]      wr_addr = '0;
   logic [31:0]     wr_data = '0;
   logic            wr_ready;
   logic            sim_tick = 1'b0;
   logic [NP*32-1:0] params;
   logic            commit_done;
   logic [3:0]      pending;
   logic            busy;
   logic [2:0]      err;
   logic            err_clear = 1'b0;

   int              n_checks = 0;
   int              n_fail = 0;
   logic [31:0]     model [NP];
   logic [NP*32-1:0] rv_v;

   param_commit_sequencer #(
      .NPARAM       (NP),
      .AW           (4),
      .DEPTH        (8),
      .RESET_VALUES (RV)
   ) dut (
      .clk_i         (clk),
      .reset_i       (rst),
      .wr_valid_i    (wr_valid),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .wr_ready_o    (wr_ready),
      .sim_tick_i    (sim_tick),
      .params_out_o  (params),
      .commit_done_o (commit_done),
      .pending_o     (pending),
      .busy_o        (busy),
      .err_flags_o   (err),
      .err_clear_i   (err_clear)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs and outputs settle 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic tick();
      sim_tick = 1'b1;
      step();
      sim_tick = 1'b0;
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < NP; i++) begin
         check_eq($sformatf("%s idx%0d", tag, i), params[32*i +: 32], model[i]);
      end
   endtask

   task automatic clear_errs();
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
   endtask

   initial begin
      rv_v = RV;
      for (int i = 0; i < NP; i++) model[i] = rv_v[32*i +: 32];
      #12;
      check_bank("reset");
      check_eq("reset idx1 literal", params[63:32], 32'h42a00000);
      check_eq("reset wr_ready", 32'(wr_ready), 32'd1);
      check_eq("reset pending", 32'(pending), 32'd0);
      check_eq("reset err", 32'(err), 32'd0);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset commit_done", 32'(commit_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Two writes to idx3: last one wins, committed 3 edges after the tick.
      push(4'd3, 32'h3e714120);
      push(4'd3, 32'h3d144674);
      check_eq("t2 pending", 32'(pending), 32'd2);
      tick();
      check_eq("t2 busy after E0", 32'(busy), 32'd1);
      step();
      step();
      check_eq("t2 idx3 E0+2", params[127:96], 32'h3f000000);
      check_eq("t2 done E0+2", 32'(commit_done), 32'd0);
      step();
      model[3] = 32'h3d144674;
      check_bank("t2 E0+3");
      check_eq("t2 done E0+3", 32'(commit_done), 32'd1);
      check_eq("t2 busy E0+3", 32'(busy), 32'd0);
      step();
      check_eq("t2 done pulse end", 32'(commit_done), 32'd0);

      // Fill, overflow, drain all eight.
      for (int i = 0; i < 8; i++) push(4'(i), 32'h41000000 + 32'(i));
      check_eq("t3 pending full", 32'(pending), 32'd8);
      check_eq("t3 wr_ready full", 32'(wr_ready), 32'd0);
      push(4'd0, 32'hdeadbeef);
      check_eq("t3 overflow err", 32'(err), 32'b001);
      check_eq("t3 pending after drop", 32'(pending), 32'd8);
      tick();
      for (int i = 0; i < 8; i++) step();
      check_eq("t3 idx7 E0+8", params[255:224], 32'hc0000000);
      check_eq("t3 done E0+8", 32'(commit_done), 32'd0);
      step();
      for (int i = 0; i < 8; i++) model[i] = 32'h41000000 + 32'(i);
      check_bank("t3 E0+9");
      check_eq("t3 done E0+9", 32'(commit_done), 32'd1);
      clear_errs();
      check_eq("t3 err cleared", 32'(err), 32'd0);

      // Write and a second tick arriving mid-drain.
      push(4'd4, 32'h44440001);
      push(4'd5, 32'h55550001);
      tick();
      wr_valid = 1'b1;
      wr_addr  = 4'd6;
      wr_data  = 32'h66660001;
      sim_tick = 1'b1;
      step();
      wr_valid = 1'b0;
      sim_tick = 1'b0;
      check_eq("t4 pending push+pop", 32'(pending), 32'd2);
      step();
      step();
      model[4] = 32'h44440001;
      model[5] = 32'h55550001;
      check_bank("t4 first commit");
      check_eq("t4 done", 32'(commit_done), 32'd1);
      check_eq("t4 overrun err", 32'(err), 32'b100);
      check_eq("t4 pending left", 32'(pending), 32'd1);
      tick();
      step();
      step();
      model[6] = 32'h66660001;
      check_bank("t4 second commit");
      check_eq("t4 done 2", 32'(commit_done), 32'd1);
      clear_errs();

      // Out-of-range address.
      push(4'd9, 32'h99999999);
      tick();
      step();
      step();
      check_bank("t5 bank unchanged");
      check_eq("t5 done", 32'(commit_done), 32'd1);
      check_eq("t5 bad addr err", 32'(err), 32'b010);
      clear_errs();

      // Reset in the middle of a five-entry drain.
      for (int i = 0; i < 5; i++) push(4'(i), 32'hbbbb0000 + 32'(i));
      tick();
      step();
      rst = 1'b1;
      #1;
      for (int i = 0; i < NP; i++) model[i] = rv_v[32*i +: 32];
      check_bank("t6 reset");
      check_eq("t6 pending", 32'(pending), 32'd0);
      check_eq("t6 busy", 32'(busy), 32'd0);
      check_eq("t6 err", 32'(err), 32'd0);
      check_eq("t6 wr_ready", 32'(wr_ready), 32'd1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq($sformatf("t6 no done c%0d", i), 32'(commit_done), 32'd0);
      end
      check_bank("t6 after release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/param_commit_sequencer.md
# param_commit_sequencer

Queues host parameter writes (32-bit IEEE-754 words such as gamma_dyn, BDAMP_1, spindle gain) and commits them atomically to a parameter bank only at simulation-step boundaries. Spindle, neuron and gain datapaths therefore never see a half-updated parameter set mid-step. The block sits between the OpalKelly wire/trigger endpoints and the spindle/izneuron parameter inputs. It runs on the raw board clock and takes a one-cycle sim-step tick from the clock generator domain (already synchronised upstream).

## Interface
- NPARAM, 8, number of 32-bit parameters in the bank (2..16)
- AW, 3, address width, ≥ clog2(NPARAM)
- DEPTH, 8, write FIFO depth, power of two (2..32)
- RESET_VALUES, {8{32'h0}}, NPARAM*32-bit reset image; parameter i at bits [32i+31:32i]

- clk  in  1  raw board clock (clk1); all logic on rising edge
- reset  in  1  asynchronous, active-high; clears everything
- wr_valid  in  1  one-cycle write request
- wr_addr  in  AW  target parameter index
- wr_data  in  32  parameter value
- wr_ready  out  1  FIFO can accept (registered occupancy < DEPTH)
- sim_tick  in  1  one-cycle pulse at each 1 ms simulation-step boundary
- params_out  out  NPARAM*32  committed parameter bank
- commit_done  out  1  one-cycle pulse when params_out has been updated
- pending  out  clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state ≠ IDLE
- err_flags  out  3  sticky: [0] overflow, [1] bad address, [2] tick overrun
- err_clear  in  1  clears err_flags (sticky set wins if same cycle)

## Operation
- Write FIFO holds {addr, data}. A write with wr_valid & wr_ready is pushed. wr_valid & ~wr_ready drops the write and sets err_flags[0].
- A shadow bank mirrors params_out. Pops write the shadow only. Commit copies shadow → params_out in one cycle.
- States:
  - IDLE: on sim_tick, snapshot cnt ← pending. If cnt>0 → DRAIN, else → COMMIT.
  - DRAIN: pop one entry per cycle into shadow[addr]; cnt−−. After the pop with cnt==1 → COMMIT.
  - COMMIT: params_out ← shadow; commit_done=1 next cycle; → IDLE.
- Entries pushed during DRAIN/COMMIT are outside the snapshot and are applied at the next tick.
- Same address written multiple times within one snapshot: FIFO order, last write wins.
- addr ≥ NPARAM: entry popped, discarded, err_flags[1] set; still counts toward cnt.
- sim_tick while busy: ignored, err_flags[2] set. The in-progress commit completes normally.
- Push and pop in the same cycle: both occur and occupancy is unchanged. wr_ready uses registered occupancy, so there is no full-bypass.
- Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- Reset values:
  - params_out = shadow = RESET_VALUES
  - FIFO empty, pending=0, wr_ready=1
  - state IDLE, busy=0, commit_done=0, err_flags=0
- Reset mid-DRAIN discards all queued and staged writes.

## Timing
- sim_tick sampled high at edge E0 with N queued entries:
  - pops occur at edges E0+1..E0+N
  - params_out updates at edge E0+N+1
  - commit_done high for the cycle following E0+N+1
- N=0: params_out reloaded (unchanged) at E0+1; commit_done still pulses.
- Worst-case latency from tick to commit: DEPTH+1 cycles, well under one sim step at 128 neuron cycles/step.
- busy asserts the cycle after E0 and deasserts with commit_done.
- pending reflects pushes and pops one cycle after the edge.
- wr_ready falls the cycle after occupancy reaches DEPTH.
- params_out is stable between commits; there are no partial updates.

## Test plan
- Reset: params_out equals RESET_VALUES (e.g. idx1 = 32'h42a00000), wr_ready=1, pending=0, err_flags=0.
- Queue writes idx3←32'h3e714120 and idx3←32'h3d144674, then sim_tick → params_out idx3 = 32'h3d144674 exactly 3 cycles after the tick, commit_done one pulse, other indices unchanged.
- Fill 8 entries, then push a 9th → 9th dropped, err_flags[0]=1, pending=8. After tick, all 8 applied at E0+9; err_clear zeroes flags.
- Write arriving during DRAIN, plus a second sim_tick during DRAIN → new write not in this commit, err_flags[2]=1. Next tick applies it.
- Write with wr_addr=9 (NPARAM=8) → bank unchanged, err_flags[1]=1, commit_done still pulses.
- Assert reset at E0+2 of a 5-entry drain → params_out back to RESET_VALUES, pending=0, busy=0, no commit_done pulse.
